// File: rtl/dmem_responder_if.sv
// Load/store handshake between the memory stage and the data-memory responder.
// The master is the memory stage; the slave is the responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency word memory serving one load/store at a time; stalls the
// pipeline while a request is in flight and pulses resp_valid on completion.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                  state, state_nxt;
  logic [3:0]              cnt;
  logic                    accept, access;
  logic                    lat_we;
  logic [31:0]             lat_addr, lat_wdata;
  logic                    acc_we, acc_err;
  logic [31:0]             acc_addr, acc_wdata;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [31:0]             mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    access        = 1'b0;
    bus.req_ready = 1'b0;
    bus.mem_stall = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.mem_stall = bus.req_valid;
        if (bus.req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            access    = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        bus.mem_stall = 1'b1;
        // cnt reaches zero on this edge: the access happens now
        if (cnt <= 4'd1) begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY==1 the access fires on the accept edge, so use the live request
  assign acc_we    = (state == IDLE) ? bus.req_we    : lat_we;
  assign acc_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
  assign acc_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;
  assign acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign acc_idx   = acc_addr[ADDR_WIDTH+1:2];

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= bus.req_we;
      lat_addr  <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= 4'd0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
    end else begin
      bus.resp_valid <= access;
      if (accept)              cnt <= CNT_INIT;
      else if (state == WAIT)  cnt <= cnt - 4'd1;
      if (access) begin
        bus.resp_err   <= acc_err;
        bus.resp_rdata <= (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // Array contents survive reset; rejected requests never write
  always_ff @(posedge clk) begin
    if (!rst && access && acc_we && !acc_err) mem[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 1) against a
// transaction-level reference model, plus directed scenarios.
module tb_dmem_responder;

  localparam int AW   = 10;
  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rv;
  logic        we;
  logic [31:0] addr, wdata;

  always #5 clk = ~clk;

  dmem_responder_if bus0();
  dmem_responder_if bus1();

  assign bus0.req_valid = rv[0];
  assign bus0.req_we    = we;
  assign bus0.req_addr  = addr;
  assign bus0.req_wdata = wdata;
  assign bus1.req_valid = rv[1];
  assign bus1.req_we    = we;
  assign bus1.req_addr  = addr;
  assign bus1.req_wdata = wdata;

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [1:0]  rdy, vld, stl, errs;
  logic [31:0] rd [2];
  assign rdy  = {bus1.req_ready,  bus0.req_ready};
  assign vld  = {bus1.resp_valid, bus0.resp_valid};
  assign stl  = {bus1.mem_stall,  bus0.mem_stall};
  assign errs = {bus1.resp_err,   bus0.resp_err};
  assign rd[0] = bus0.resp_rdata;
  assign rd[1] = bus1.resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model (transaction level) ----------------
  longint      e_now = 0;
  bit          model_live = 0;
  bit          pend  [2];
  longint      acc_e [2];
  longint      free_e[2];
  logic        pw    [2];
  logic [31:0] pa    [2];
  logic [31:0] pd    [2];
  logic        ev    [2];
  logic [31:0] erd   [2];
  logic        eerr  [2];
  bit          eknown[2];
  logic [31:0] mmem [int];

  always @(posedge clk) begin
    e_now = e_now + 1;
    for (int k = 0; k < 2; k++) begin
      int lt;
      bit bad;
      int key;
      lt = (k == 0) ? LAT0 : LAT1;
      if (rst) begin
        pend[k]   = 0;
        free_e[k] = e_now + 1;
        ev[k]     = 1'b0;
        erd[k]    = 32'd0;
        eerr[k]   = 1'b0;
        eknown[k] = 1;
      end else begin
        ev[k] = 1'b0;
        if (rv[k] && e_now >= free_e[k]) begin
          pend[k]   = 1;
          acc_e[k]  = e_now;
          free_e[k] = e_now + lt + 1;
          pw[k] = we; pa[k] = addr; pd[k] = wdata;
        end
        if (pend[k] && e_now == acc_e[k] + lt - 1) begin
          pend[k] = 0;
          ev[k]   = 1'b1;
          bad = (pa[k] % 4 != 0) || (pa[k] >= 32'(4 * (1 << AW)));
          key = k * 65536 + int'(pa[k] >> 2);
          if (bad) begin
            erd[k] = 32'd0; eerr[k] = 1'b1; eknown[k] = 1;
          end else if (pw[k]) begin
            mmem[key] = pd[k];
            erd[k] = 32'd0; eerr[k] = 1'b0; eknown[k] = 1;
          end else begin
            eerr[k] = 1'b0;
            if (mmem.exists(key)) begin
              erd[k] = mmem[key]; eknown[k] = 1;
            end else begin
              eknown[k] = 0;
            end
          end
        end
      end
    end
    model_live = 1;
  end

  always begin
    @(negedge clk);
    #2;
    if (model_live) begin
      for (int k = 0; k < 2; k++) begin
        logic er, es;
        er = (e_now + 1 >= free_e[k]);
        es = (er & rv[k]) | pend[k];
        chk($sformatf("req_ready[%0d]", k),  32'(rdy[k]),  32'(er));
        chk($sformatf("mem_stall[%0d]", k),  32'(stl[k]),  32'(es));
        chk($sformatf("resp_valid[%0d]", k), 32'(vld[k]),  32'(ev[k]));
        chk($sformatf("resp_err[%0d]", k),   32'(errs[k]), 32'(eerr[k]));
        if (eknown[k]) chk($sformatf("resp_rdata[%0d]", k), rd[k], erd[k]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic xact(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdata, output logic err, output int lat_seen,
                      output int stall_n);
    int n;
    @(negedge clk);
    we = w; addr = a; wdata = d; rv[k] = 1'b1;
    stall_n = 0; n = 0;
    forever begin
      #1;
      if (stl[k]) stall_n++;
      if (rdy[k]) break;
      if (n >= 20) begin chk("accept_timeout", 32'd0, 32'd1); break; end
      @(negedge clk); n++;
    end
    @(negedge clk);
    rv[k] = 1'b0;
    lat_seen = 1;
    forever begin
      #1;
      if (vld[k]) break;
      if (stl[k]) stall_n++;
      if (lat_seen >= 20) begin chk("resp_timeout", 32'd0, 32'd1); break; end
      @(negedge clk); lat_seen++;
    end
    rdata = rd[k];
    err   = errs[k];
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          lt, st, n, last, got;
    rst = 1'b1; rv = 2'b00; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_ready0", 32'(rdy[0]), 32'd1);
    chk("reset_valid0", 32'(vld[0]), 32'd0);
    chk("reset_rdata0", rd[0], 32'd0);
    chk("reset_stall0", 32'(stl[0]), 32'd0);

    // LATENCY=2 store then load
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, r, e, lt, st);
    chk("st10_latency", lt, 32'd2);
    chk("st10_stall",   st, 32'd2);
    chk("st10_err",     32'(e), 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, r, e, lt, st);
    chk("ld10_rdata",   r, 32'hDEADBEEF);
    chk("ld10_latency", lt, 32'd2);
    chk("ld10_stall",   st, 32'd2);

    // misaligned load
    xact(0, 1'b0, 32'h13, 32'h0, r, e, lt, st);
    chk("ld13_err",     32'(e), 32'd1);
    chk("ld13_rdata",   r, 32'd0);
    chk("ld13_latency", lt, 32'd2);
    xact(0, 1'b0, 32'h10, 32'h0, r, e, lt, st);
    chk("ld10_again",   r, 32'hDEADBEEF);

    // out-of-range store must not alias onto word 0
    xact(0, 1'b1, 32'h0, 32'hCAFEF00D, r, e, lt, st);
    xact(0, 1'b1, 32'h1000, 32'h5555AAAA, r, e, lt, st);
    chk("st1000_err", 32'(e), 32'd1);
    xact(0, 1'b0, 32'h0, 32'h0, r, e, lt, st);
    chk("ld0_rdata", r, 32'hCAFEF00D);
    chk("ld0_err",   32'(e), 32'd0);

    // back-to-back loads with req_valid held
    @(negedge clk);
    we = 1'b0; addr = 32'h10; rv[0] = 1'b1;
    last = -1; got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      #1;
      if (rdy[0]) begin
        if (last >= 0) chk("b2b_spacing", 32'(int'(e_now) + 1 - last), 32'(LAT0 + 1));
        last = int'(e_now) + 1;
        got++;
      end
      @(negedge clk);
    end
    rv[0] = 1'b0;
    chk("b2b_accepts", 32'(got), 32'd4);

    // reset during WAIT of a store abandons it
    xact(0, 1'b1, 32'h20, 32'h11111111, r, e, lt, st);
    xact(0, 1'b0, 32'h20, 32'h0, r, e, lt, st);
    chk("ld20_pre", r, 32'h11111111);
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'h99999999; rv[0] = 1'b1;
    n = 0;
    forever begin
      #1;
      if (rdy[0]) break;
      if (n >= 20) begin chk("rst_accept_timeout", 32'd0, 32'd1); break; end
      @(negedge clk); n++;
    end
    @(negedge clk);
    rv[0] = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstwait_valid", 32'(vld[0]),  32'd0);
    chk("rstwait_rdata", rd[0],        32'd0);
    chk("rstwait_err",   32'(errs[0]), 32'd0);
    chk("rstwait_ready", 32'(rdy[0]),  32'd1);
    repeat (3) @(negedge clk);
    xact(0, 1'b0, 32'h20, 32'h0, r, e, lt, st);
    chk("ld20_post", r, 32'h11111111);

    // LATENCY=1 instance
    xact(1, 1'b1, 32'h4, 32'h12345678, r, e, lt, st);
    chk("l1_st_latency", lt, 32'd1);
    chk("l1_st_stall",   st, 32'd1);
    xact(1, 1'b0, 32'h4, 32'h0, r, e, lt, st);
    chk("l1_ld_rdata",   r, 32'h12345678);
    chk("l1_ld_latency", lt, 32'd1);
    chk("l1_ld_stall",   st, 32'd1);

    // randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      int sel;
      @(negedge clk);
      rv    = 2'($urandom_range(0, 3));
      we    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      rst   = ($urandom_range(0, 149) == 0);
      sel   = $urandom_range(0, 9);
      if (sel < 7)       addr = 32'($urandom_range(0, 15)) * 32'd4;
      else if (sel == 7) addr = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
      else if (sel == 8) addr = 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4;
      else               addr = 32'h8000_0000 | (32'($urandom_range(0, 15)) * 32'd4);
    end
    @(negedge clk);
    rv = 2'b00; rst = 1'b0;
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder at the far end of the pipeline's memory-stage load/store interface. It accepts one word request at a time from the memory stage and services it from an internal word array after a fixed, parameterised latency. It returns read data with a one-cycle response pulse. While a request is outstanding it drives a stall to the hazard unit, which replaces the zero-latency behavioural data memory once the pipeline must tolerate slow memory.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-index width. The array holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 2: cycles from request accept to `resp_valid`. Legal range is 1..15.

Ports:
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: memory stage presents a load or store.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `req_ready` out 1: request accepted this cycle when `req_valid & req_ready`.
- `resp_valid` out 1: one-cycle pulse; request complete.
- `resp_rdata` out 32: load data, valid while `resp_valid`.
- `resp_err` out 1: request rejected (misaligned or out of range); valid while `resp_valid`.
- `mem_stall` out 1: to the hazard unit; freezes fetch, decode, execute and memory while high.

## Operation
State machine: IDLE, WAIT, RESP.

IDLE:
- `req_ready` = 1.
- On `req_valid`, latch `we`, `addr` and `wdata`, and load a counter with `LATENCY-1`.
- If `LATENCY==1`, go directly to RESP. Otherwise go to WAIT.

WAIT:
- `req_ready` = 0. The counter decrements each cycle.
- When the counter reaches 0, perform the access on that edge and go to RESP.
- Loads: `resp_rdata` is registered as `mem[addr[ADDR_WIDTH+1:2]]`.
- Stores: write the array. `resp_rdata` is registered as 0.

RESP:
- `resp_valid` = 1 and `req_ready` = 0.
- Unconditionally return to IDLE next cycle. A request presented in RESP waits for IDLE.

Error check, evaluated on the latched request:
- Error if `addr[1:0] != 0` or any of `addr[31:ADDR_WIDTH+2]` is nonzero.
- On error: no array write, `resp_rdata` = 0, `resp_err` = 1. Latency is unchanged.

`mem_stall` = `(state==IDLE & req_valid) | state==WAIT`. It is low in RESP, so the memory stage captures `resp_rdata` and advances on that edge.

Outputs are registered. `resp_rdata` and `resp_err` hold their last values outside RESP, but consumers must qualify them with `resp_valid`.

The array has no byte enables; every access is a full word.

## Timing
Reset:
- Next edge: state = IDLE, counter = 0, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0.
- `req_ready` = 1 and `mem_stall` = `req_valid` immediately after reset.
- Array contents are not reset.

Request sequence, accepted at edge T:
- WAIT during cycles T+1 .. T+LATENCY-1.
- `resp_valid` high in cycle T+LATENCY.
- IDLE again at T+LATENCY+1.
- Maximum throughput is one request per LATENCY+1 cycles.

Stall window: `mem_stall` is high from the cycle `req_valid` first rises in IDLE through cycle T+LATENCY-1, i.e. exactly LATENCY cycles.

Ordering: the write commits at the edge entering RESP. A load accepted afterwards returns the new data (read-after-write coherent).

Inputs are sampled only at accept. Changes on `req_*` during WAIT or RESP are ignored.

Reset mid-operation: a synchronous `rst` in WAIT abandons the request. No write occurs and no `resp_valid` is issued. Reset during RESP clears `resp_valid` on that edge.

Simultaneous `rst` and `req_valid`: reset wins and the request is not accepted.

## Test plan
- LATENCY=2, store `0xDEADBEEF` to `0x0000_0010`, then load `0x10` -> each sees `mem_stall` high 2 cycles, `resp_valid` at T+2, and the load returns `0xDEADBEEF` with `resp_err` 0.
- Load from `0x0000_0013` (misaligned) -> `resp_valid` at T+2 with `resp_err` 1 and `resp_rdata` 0. A follow-up load of `0x10` still returns the prior data.
- ADDR_WIDTH=10, store to `0x0000_1000` (out of range) -> `resp_err` 1, no write. A load of `0x0` is unchanged.
- Back-to-back loads with `req_valid` held high -> accepts are spaced exactly LATENCY+1 cycles apart, and `req_ready` is low in WAIT and RESP.
- Assert `rst` for one cycle in WAIT of a store to `0x20` -> no `resp_valid`, outputs 0, state IDLE. A later load of `0x20` returns the pre-store value.
- LATENCY=1: store then load `0x4` with value `0x1234_5678` -> IDLE goes straight to RESP, `resp_valid` at T+1, `mem_stall` high for 1 cycle, and the load returns `0x12345678`.
